usb_rst_sequencer: RTL

- Avalon-MM master that drives the USB reset PIO slave, the initiator side of that register interface.
- On a start pulse it:
  - writes 1 to the PIO data register (address 0) and reads it back to confirm;
  - holds reset for a programmed time;
  - writes 0 and confirms it;
  - waits a settle time, then reports done.
- Sits between platform control logic and the PIO slave, so the USB controller reset needs no CPU involvement.

---
 rtl/usb_rst_sequencer_if.sv | 28 ++
 rtl/usb_rst_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM register port between the USB reset sequencer (master) and the
// reset PIO slave.
interface usb_rst_sequencer_if;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_read,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_read,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/usb_rst_sequencer.sv
// Drives the USB reset PIO through assert / hold / deassert / settle, confirming
// every register write with a readback and retrying a bounded number of times.
module usb_rst_sequencer #(
  parameter int HOLD_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  usb_rst_sequencer_if.master  avm
);

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  // Counters hold "cycles remaining minus one" so the exit test is a compare to zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE,
    WR_ASSERT,
    RD_ASSERT,
    HOLD,
    WR_DEASSERT,
    RD_DEASSERT,
    SETTLE,
    DONE,
    FAIL,
    FAIL_END
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RTY_W-1:0] rty_reg, rty_next;
  logic             error_reg, error_next;

  logic             write_c;
  logic             read_c;
  logic [31:0]      writedata_c;
  logic             busy_c;
  logic             done_c;
  logic             rd_bit;
  logic             unused_readdata_hi;

  assign rd_bit             = avm.avm_readdata[0];
  assign unused_readdata_hi = ^avm.avm_readdata[31:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rty_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rty_reg   <= rty_next;
      error_reg <= error_next;
    end
  end

  // Outputs are decoded from the state alone, so the request, address and
  // writedata stay put for as long as the slave stalls.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rty_next    = rty_reg;
    error_next  = error_reg;
    write_c     = 1'b0;
    read_c      = 1'b0;
    writedata_c = 32'h0;
    busy_c      = 1'b0;
    done_c      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WR_ASSERT;
          error_next = 1'b0;
          rty_next   = '0;
        end
      end

      WR_ASSERT: begin
        busy_c      = 1'b1;
        write_c     = 1'b1;
        writedata_c = 32'h1;
        if (!avm.avm_waitrequest) begin
          state_next = RD_ASSERT;
        end
      end

      RD_ASSERT: begin
        busy_c = 1'b1;
        read_c = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (rd_bit) begin
            state_next = HOLD;
            rty_next   = '0;
            cnt_next   = HOLD_LOAD;
          end else if (rty_reg < RTY_LIMIT) begin
            state_next = WR_ASSERT;
            rty_next   = rty_reg + RTY_W'(1);
          end else begin
            state_next = FAIL;
          end
        end
      end

      HOLD: begin
        busy_c = 1'b1;
        if (cnt_reg == '0) begin
          state_next = WR_DEASSERT;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      WR_DEASSERT: begin
        busy_c      = 1'b1;
        write_c     = 1'b1;
        writedata_c = 32'h0;
        if (!avm.avm_waitrequest) begin
          state_next = RD_DEASSERT;
        end
      end

      RD_DEASSERT: begin
        busy_c = 1'b1;
        read_c = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (!rd_bit) begin
            rty_next = '0;
            if (SETTLE_CYCLES == 0) begin
              state_next = DONE;
            end else begin
              state_next = SETTLE;
              cnt_next   = SETTLE_LOAD;
            end
          end else if (rty_reg < RTY_LIMIT) begin
            state_next = WR_DEASSERT;
            rty_next   = rty_reg + RTY_W'(1);
          end else begin
            state_next = FAIL;
          end
        end
      end

      SETTLE: begin
        busy_c = 1'b1;
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      // Leave the controller out of reset on the way out, whatever the slave said.
      FAIL: begin
        busy_c      = 1'b1;
        write_c     = 1'b1;
        writedata_c = 32'h0;
        if (!avm.avm_waitrequest) begin
          state_next = FAIL_END;
          error_next = 1'b1;
        end
      end

      // error rises here with busy low; a start in this cycle is not accepted.
      FAIL_END: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy              = busy_c;
  assign done              = done_c;
  assign error             = error_reg;
  assign avm.avm_address   = 2'd0;
  assign avm.avm_write     = write_c;
  assign avm.avm_read      = read_c;
  assign avm.avm_writedata = writedata_c;

endmodule
